vga_video_pipe: RTL

//   Parametrised VGA timing generator and pixel output stage for the POS display.
//   - Generates the pixel tick, pixel coordinates and sync pulses for any resolution.
//   - Requests pixels from an external image source and absorbs the source's fixed latency.
//   - Emits latency-aligned sync, blank and gated RGB to the DAC.
//   - Replaces the fixed 640x480, zero-latency sync plus top-level gating combination.

---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_sync_delay.sv | 34 +++
 rtl/vga_video_pipe.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared timing presets, counter-width helper and the {hs,vs,active} sync bundle
// used by the VGA timing generator and its alignment delay line.
package vga_pkg;

  // 640x480 @ 60 Hz (25.175 MHz pixel clock), negative syncs.
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;

  // 800x600 @ 60 Hz (40 MHz pixel clock), positive syncs.
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;

  localparam int PAT_BARS = 8;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_bundle_t;

endpackage

// File: rtl/vga_sync_delay.sv
// Tick-enabled shift register that delays the sync bundle (plus pattern colour
// when present) by DEPTH pixel ticks; DEPTH 0 is a plain wire.
module vga_sync_delay #(
  parameter int DEPTH = 1,
  parameter int W     = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_bypass;
    assign unused_bypass = clk ^ rst_n ^ en_i;
    assign q_o = d_i;
  end else begin : g_pipe
    logic [W-1:0] pipe_q [DEPTH];

    // NOTE: the delay line is reset because its contents drive sync and blank at the pins.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
      end else if (en_i) begin
        pipe_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign q_o = pipe_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_video_pipe.sv
// Parametrised VGA timing generator and latency-aligned pixel output stage.
// Optional colour-bar generator enabled by defining VGA_TEST_PATTERN_EN.
module vga_video_pipe
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = VGA640_H_ACTIVE,
  parameter int H_FP        = VGA640_H_FP,
  parameter int H_SYNC      = VGA640_H_SYNC,
  parameter int H_BP        = VGA640_H_BP,
  parameter int V_ACTIVE    = VGA640_V_ACTIVE,
  parameter int V_FP        = VGA640_V_FP,
  parameter int V_SYNC      = VGA640_V_SYNC,
  parameter int V_BP        = VGA640_V_BP,
  parameter int CLK_DIV     = 2,
  parameter int PIX_LATENCY = 1,
  parameter int COLOR_W     = 8,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  output logic                                                pix_tick,
  output logic [cnt_w(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]         x,
  output logic [cnt_w(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]         y,
  output logic                                                active,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                                                pattern_sel,
`endif
  input  logic [COLOR_W-1:0]                                  pix_r,
  input  logic [COLOR_W-1:0]                                  pix_g,
  input  logic [COLOR_W-1:0]                                  pix_b,
  output logic                                                hsync,
  output logic                                                vsync,
  output logic                                                blank_n,
  output logic                                                sync_n,
  output logic [COLOR_W-1:0]                                  red,
  output logic [COLOR_W-1:0]                                  green,
  output logic [COLOR_W-1:0]                                  blue,
  output logic                                                frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = cnt_w(H_TOTAL);
  localparam int YW      = cnt_w(V_TOTAL);
  localparam int DW      = cnt_w(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          pix_tick_q;
  logic          tick_dly_q;

  sync_bundle_t  raw_s, dly_s;
  logic [COLOR_W-1:0] src_r, src_g, src_b;
  logic          hsync_q, vsync_q, blank_q;
  logic [COLOR_W-1:0] red_q, green_q, blue_q;

  always_comb begin
    // NOTE: every variable gets its default first so no branch can infer a latch.
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    x_d       = x_q;
    y_d       = y_q;
    if (pix_tick_q) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // pix_tick is registered from the next divider value so it is low in reset
  // yet still coincides with div_cnt == CLK_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking for all state so every register samples pre-edge values.
    if (!rst_n) begin
      div_cnt_q  <= '0;
      pix_tick_q <= 1'b0;
      tick_dly_q <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      pix_tick_q <= (div_cnt_d == DIV_LAST);
      tick_dly_q <= pix_tick_q;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  always_comb begin
    raw_s        = '0;
    raw_s.hs     = (int'(x_q) >= H_ACTIVE + H_FP) && (int'(x_q) < H_ACTIVE + H_FP + H_SYNC);
    raw_s.vs     = (int'(y_q) >= V_ACTIVE + V_FP) && (int'(y_q) < V_ACTIVE + V_FP + V_SYNC);
    raw_s.active = (int'(x_q) < H_ACTIVE) && (int'(y_q) < V_ACTIVE);
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE >= PAT_BARS) ? H_ACTIVE / PAT_BARS : 1;
  localparam int DLY_W = $bits(sync_bundle_t) + 3;

  logic [2:0]       bar_s, dly_bar;
  logic [DLY_W-1:0] dly_out;

  assign bar_s = 3'(int'(x_q) / BAR_W);

  vga_sync_delay #(.DEPTH(PIX_LATENCY), .W(DLY_W)) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (pix_tick_q),
    .d_i   ({raw_s, bar_s}),
    .q_o   (dly_out)
  );

  assign {dly_s, dly_bar} = dly_out;

  always_comb begin
    src_r = pix_r;
    src_g = pix_g;
    src_b = pix_b;
    if (pattern_sel) begin
      src_r = {COLOR_W{dly_bar[2]}};
      src_g = {COLOR_W{dly_bar[1]}};
      src_b = {COLOR_W{dly_bar[0]}};
    end
  end
`else
  vga_sync_delay #(.DEPTH(PIX_LATENCY), .W($bits(sync_bundle_t))) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (pix_tick_q),
    .d_i   (raw_s),
    .q_o   (dly_s)
  );

  always_comb begin
    src_r = pix_r;
    src_g = pix_g;
    src_b = pix_b;
  end
`endif

  // Output stage loads one clk after the tick, when the delay line and the
  // source have both settled on the same pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      blank_q <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else if (tick_dly_q) begin
      hsync_q <= dly_s.hs ? HS_POL : ~HS_POL;
      vsync_q <= dly_s.vs ? VS_POL : ~VS_POL;
      blank_q <= dly_s.active;
      red_q   <= dly_s.active ? src_r : '0;
      green_q <= dly_s.active ? src_g : '0;
      blue_q  <= dly_s.active ? src_b : '0;
    end
  end

  assign pix_tick    = pix_tick_q;
  assign x           = x_q;
  assign y           = y_q;
  assign active      = raw_s.active;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign blank_n     = blank_q;
  assign sync_n      = 1'b1;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign frame_start = pix_tick_q && (x_q == '0) && (y_q == '0);

endmodule
